// File: rtl/piso_serialiser_pkg.sv
// Shared definitions for the serial transmit/receive family:
// FSM states, bit-order encoding and the counter width helper.
package piso_serialiser_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic ORDER_LSB_FIRST = 1'b0;
    localparam logic ORDER_MSB_FIRST = 1'b1;

    // Width of a counter that must hold N-1; kept at least 1 bit wide.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serialiser_counter.sv
// Loadable down-counter with zero flag, used to count bits within a word.
// Shared in spirit with the matching deserialiser.
module down_counter_ld #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load wins over decrement; the counter never wraps because the
    // owner only decrements while the count is non-zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/piso_serialiser.sv
// Parallel-in serial-out transmitter with VALID/READY load, per-word bit
// order and gap-free back-to-back words.
module piso_serialiser
    import piso_serialiser_pkg::*;
#(
    parameter int   N          = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         EN,
    input  logic         LOAD_VALID,
    output logic         LOAD_READY,
    input  logic [N-1:0] DATAW,
    input  logic         MSB_FIRST,
    output logic         SOUT,
    output logic         SVALID,
    output logic         LAST,
    output logic         o_dbg_state
);

    localparam int CW = cnt_width(N);

    // Handshake: a word transfers on a rising edge where EN, LOAD_VALID and
    // LOAD_READY are all high. LOAD_READY depends only on registered state.
    state_e         r_state;
    logic [N-1:0]   r_sr;
    logic           r_order;
    logic [CW-1:0]  w_cnt;
    logic           w_zero;
    logic           w_shift;
    logic           w_accept;
    logic           w_dec;

    assign w_shift    = (r_state == ST_SHIFT);
    assign LOAD_READY = !w_shift || w_zero;
    assign w_accept   = EN && LOAD_VALID && LOAD_READY;
    assign w_dec      = EN && w_shift && !w_zero;

    down_counter_ld #(.W(CW)) u_bit_cnt (
        .i_clk      (CLK),
        .i_rst_n    (N_RESET),
        .i_load     (w_accept),
        .i_load_val (CW'(N - 1)),
        .i_dec      (w_dec),
        .o_cnt      (w_cnt),
        .o_zero     (w_zero)
    );

    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_order <= ORDER_LSB_FIRST;
        end else if (EN) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sr    <= DATAW;
                        r_order <= MSB_FIRST;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!w_zero) begin
                        r_sr <= (r_order == ORDER_MSB_FIRST) ? {r_sr[N-2:0], 1'b0}
                                                              : {1'b0, r_sr[N-1:1]};
                    end else if (w_accept) begin
                        // Next word loads on the last bit: no idle gap.
                        r_sr    <= DATAW;
                        r_order <= MSB_FIRST;
                    end else begin
                        r_sr    <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign SVALID      = w_shift;
    assign LAST        = w_shift && w_zero;
    assign SOUT        = w_shift ? ((r_order == ORDER_MSB_FIRST) ? r_sr[N-1] : r_sr[0])
                                 : IDLE_LEVEL;
    assign o_dbg_state = w_shift;

endmodule

// File: tb/tb_piso_serialiser.sv
// Scoreboard bench for piso_serialiser: words are expanded into expected
// (bit, last) pairs on accept and a monitor consumes them per enabled cycle.
module tb_piso_serialiser;

    localparam int   N          = 8;
    localparam logic IDLE_LEVEL = 1'b0;

    logic         CLK;
    logic         N_RESET;
    logic         EN;
    logic         LOAD_VALID;
    logic         LOAD_READY;
    logic [N-1:0] DATAW;
    logic         MSB_FIRST;
    logic         SOUT;
    logic         SVALID;
    logic         LAST;
    logic         dbg_state;

    logic [1:0]   exp_q[$];
    logic [1:0]   mon_front;
    int           n_pass;
    int           n_total;

    piso_serialiser #(.N(N), .IDLE_LEVEL(IDLE_LEVEL)) dut (
        .CLK         (CLK),
        .N_RESET     (N_RESET),
        .EN          (EN),
        .LOAD_VALID  (LOAD_VALID),
        .LOAD_READY  (LOAD_READY),
        .DATAW       (DATAW),
        .MSB_FIRST   (MSB_FIRST),
        .SOUT        (SOUT),
        .SVALID      (SVALID),
        .LAST        (LAST),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a word becomes N serial bits in the chosen order,
    // the final one flagged as last.
    task automatic push_word(input logic [N-1:0] w, input logic o);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({(o ? w[N-1-i] : w[i]), (i == N - 1)});
        end
    endtask

    // Driver: offer a word, push its expectation when the transfer happens.
    task automatic send(input logic [N-1:0] w, input logic o, input bit jitter);
        int budget;
        bit acc;
        budget = 0;
        acc = 1'b0;
        DATAW = w;
        MSB_FIRST = o;
        LOAD_VALID = 1'b1;
        while (!acc) begin
            @(negedge CLK);
            #1;
            acc = EN && LOAD_READY;
            if (acc) push_word(w, o);
            @(posedge CLK);
            #1;
            if (jitter) EN = ($urandom_range(0, 3) != 0);
            if (!acc) begin
                budget++;
                if (budget > 200) begin
                    check("accept_timeout", 32'd0, 32'd1);
                    acc = 1'b1;
                end
            end
        end
        LOAD_VALID = 1'b0;
        DATAW = N'($urandom);
        MSB_FIRST = 1'($urandom);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 500) begin
            @(posedge CLK);
            #1;
            budget++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    // Monitor: SVALID must be high exactly while bits are pending; the
    // front bit is consumed only on enabled cycles, so EN=0 checks freeze.
    always @(negedge CLK) begin
        if (N_RESET) begin
            check("svalid", 32'(SVALID), 32'(exp_q.size() != 0));
            check("load_ready", 32'(LOAD_READY), 32'(exp_q.size() <= 1));
            check("dbg_state", 32'(dbg_state), 32'(exp_q.size() != 0));
            if (SVALID && exp_q.size() != 0) begin
                mon_front = exp_q[0];
                check("sout", 32'(SOUT), 32'(mon_front[1]));
                check("last", 32'(LAST), 32'(mon_front[0]));
                if (EN) void'(exp_q.pop_front());
            end else if (!SVALID) begin
                check("sout_idle", 32'(SOUT), 32'(IDLE_LEVEL));
                check("last_idle", 32'(LAST), 32'd0);
            end
        end
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        N_RESET = 1'b0;
        EN = 1'b1;
        LOAD_VALID = 1'b0;
        DATAW = '0;
        MSB_FIRST = 1'b0;
        #3;
        check("rst_sout", 32'(SOUT), 32'(IDLE_LEVEL));
        check("rst_svalid", 32'(SVALID), 32'd0);
        check("rst_last", 32'(LAST), 32'd0);
        check("rst_ready", 32'(LOAD_READY), 32'd1);
        #19 N_RESET = 1'b1;
        @(posedge CLK);
        #1;

        // LSB first, MSB first, then back-to-back with LOAD_VALID held.
        send(8'h01, 1'b0, 1'b0);
        drain();
        send(8'h01, 1'b1, 1'b0);
        drain();
        send(8'hFF, 1'b0, 1'b0);
        send(8'h0F, 1'b0, 1'b0);
        drain();

        // EN gap of 3 cycles after the second bit.
        send(8'hA5, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        EN = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        EN = 1'b1;
        drain();

        // Asynchronous reset mid-word, then a clean word.
        send(8'hFF, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        #1 N_RESET = 1'b0;
        #1;
        check("arst_sout", 32'(SOUT), 32'(IDLE_LEVEL));
        check("arst_svalid", 32'(SVALID), 32'd0);
        check("arst_last", 32'(LAST), 32'd0);
        check("arst_ready", 32'(LOAD_READY), 32'd1);
        exp_q.delete();
        #1 N_RESET = 1'b1;
        send(8'h80, 1'b0, 1'b0);
        drain();

        // LOAD_VALID while EN=0 in IDLE: no accept until EN returns.
        EN = 1'b0;
        fork
            send(8'h3C, 1'b1, 1'b0);
            begin
                repeat (3) @(posedge CLK);
                #1;
                check("no_accept_en0", 32'(dbg_state), 32'd0);
                EN = 1'b1;
            end
        join
        drain();

        // Random words, orders, gaps and EN jitter.
        for (int k = 0; k < 25; k++) begin
            send(N'($urandom), 1'($urandom), 1'b1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge CLK);
                #1;
            end
        end
        EN = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
